// File: rtl/instr_refill_ctrl_pkg.sv
// instr_refill_ctrl_pkg
//   Shared definitions for the instruction-cache refill path: refill FSM
//   state encoding and the helpers that derive the beat count and beat-index
//   width from the cache block size. Every cache-side module that walks a
//   refill line uses these, so they all agree on how a line maps onto beats.
package instr_refill_ctrl_pkg;

    // Refill sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_FILL   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } refillState_e;

    // One L2 response beat carries 64 bits.
    localparam int BEAT_BYTES          = 8;
    localparam int DEFAULT_BLOCK_BYTES = 64;

    // Number of beats needed to move one cache block.
    function automatic int beatsOf(input int blockBytes);
        return blockBytes / BEAT_BYTES;
    endfunction

    // Width of an index that addresses one beat within a block.
    function automatic int beatIdxW(input int blockBytes);
        return $clog2(blockBytes / BEAT_BYTES);
    endfunction

    localparam int DEFAULT_BEATS = beatsOf(DEFAULT_BLOCK_BYTES);

endpackage

// File: rtl/instr_refill_ctrl_line_buffer.sv
// refill_line_buffer
//   Holds one cache line while it is collected from L2 and then replayed
//   toward the cache set. DEPTH entries of 64 bits, one synchronous write
//   port and one combinational read port. Contents are deliberately not
//   reset: every entry is written before it is read in a refill.
//
// Ports
//   clk     in   clock
//   wrEn    in   write strobe
//   wrIdx   in   write entry index
//   wrData  in   write data
//   rdIdx   in   read entry index
//   rdData  out  read data (combinational)
module refill_line_buffer #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic [63:0]      wrData,
    input  logic [IDX_W-1:0] rdIdx,
    output logic [63:0]      rdData
);

    logic [63:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrIdx] <= wrData;
        end
    end

    assign rdData = mem[rdIdx];

endmodule

// File: rtl/instr_refill_ctrl.sv
// instr_refill_ctrl
//   Instruction-cache miss refill sequencer. On a miss it requests the
//   aligned line from L2, collects BEATS response beats into a line buffer,
//   then streams the whole line toward the cache set in BEATS back-to-back
//   cycles. A redirect (Flush) cancels the refill: before L2 accepts the
//   request the controller simply drops it; once accepted it must still
//   drain every beat L2 owes, but the line is never streamed.
//
// Ports
//   clk           in   clock, all state on rising edge
//   reset         in   asynchronous active-low reset
//   CacheMiss     in   miss from the active cache set
//   PC[ADDR_W]    in   fetch address of the missing instruction
//   Flush         in   pipeline redirect
//   MemReq        out  line request valid to L2
//   MemAddr       out  line-aligned request address
//   MemReqReady   in   L2 accepts request
//   MemRespValid  in   response beat valid
//   MemRespData   in   response beat (64 bits)
//   RepEnable     out  refill stream active toward cache set
//   RepWord       out  refill beat toward cache set (0 when idle)
//   FetchStall    out  hold fetch stage
module instr_refill_ctrl
    import instr_refill_ctrl_pkg::*;
#(
    parameter int B      = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CacheMiss,
    input  logic [ADDR_W-1:0] PC,
    input  logic              Flush,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemReqReady,
    input  logic              MemRespValid,
    input  logic [63:0]       MemRespData,
    output logic              RepEnable,
    output logic [63:0]       RepWord,
    output logic              FetchStall
);

    localparam int BEATS  = beatsOf(B);
    localparam int BEAT_W = beatIdxW(B);

    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(B - 1);

    refillState_e      state, stateNext;
    logic [BEAT_W-1:0] beatCnt, beatCntNext;
    logic              discard, discardNext;
    logic [ADDR_W-1:0] lineAddr, lineAddrNext;
    logic              bufWe;
    logic [63:0]       bufRdData;

    // The same counter indexes the buffer for both collection and replay;
    // the two phases never overlap.
    refill_line_buffer #(
        .DEPTH (BEATS),
        .IDX_W (BEAT_W)
    ) lineBuf (
        .clk    (clk),
        .wrEn   (bufWe),
        .wrIdx  (beatCnt),
        .wrData (MemRespData),
        .rdIdx  (beatCnt),
        .rdData (bufRdData)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beatCnt  <= '0;
            discard  <= 1'b0;
            lineAddr <= '0;
        end else begin
            beatCnt  <= beatCntNext;
            discard  <= discardNext;
            lineAddr <= lineAddrNext;
        end
    end

    always_comb begin
        stateNext    = state;
        beatCntNext  = beatCnt;
        discardNext  = discard;
        lineAddrNext = lineAddr;
        bufWe        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (CacheMiss && !Flush) begin
                    lineAddrNext = PC & ~OFFSET_MASK;
                    stateNext    = ST_REQ;
                end
            end

            ST_REQ: begin
                // Once L2 has taken the request it will return a full line
                // regardless, so a redirect on the accept edge still has to
                // drain; it just marks the line as unwanted.
                if (MemReqReady) begin
                    stateNext   = ST_FILL;
                    beatCntNext = '0;
                    discardNext = Flush;
                end else if (Flush) begin
                    stateNext = ST_IDLE;
                end
            end

            ST_FILL: begin
                if (Flush) begin
                    discardNext = 1'b1;
                end
                if (MemRespValid) begin
                    bufWe       = 1'b1;
                    beatCntNext = beatCnt + 1'b1;
                    if (beatCnt == LAST_BEAT) begin
                        beatCntNext = '0;
                        // A redirect arriving with the final beat still
                        // suppresses the stream.
                        if (discard || Flush) begin
                            stateNext   = ST_IDLE;
                            discardNext = 1'b0;
                        end else begin
                            stateNext = ST_STREAM;
                        end
                    end
                end
            end

            ST_STREAM: begin
                beatCntNext = beatCnt + 1'b1;
                if (beatCnt == LAST_BEAT) begin
                    beatCntNext = '0;
                    stateNext   = ST_DONE;
                end
            end

            ST_DONE: begin
                stateNext = ST_IDLE;
            end

            default: begin
                stateNext   = ST_IDLE;
                beatCntNext = '0;
                discardNext = 1'b0;
            end
        endcase
    end

    assign MemReq     = (state == ST_REQ);
    assign MemAddr    = lineAddr;
    assign RepEnable  = (state == ST_STREAM);
    assign RepWord    = RepEnable ? bufRdData : 64'd0;
    assign FetchStall = (state != ST_IDLE) || (CacheMiss && !Flush);

endmodule

// File: tb/tb_instr_refill_ctrl.sv
// tb_instr_refill_ctrl
//   Drives miss transactions against instr_refill_ctrl and checks the
//   observable behaviour cycle by cycle against a transaction-level
//   expectation: each transaction's expected address, beat list and phase
//   lengths are derived from the miss PC, the chosen handshake timing and
//   the data the bench itself supplied.
module tb_instr_refill_ctrl;

    localparam int B      = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = B / 8;

    logic              clk;
    logic              reset;
    logic              CacheMiss;
    logic [ADDR_W-1:0] PC;
    logic              Flush;
    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemReqReady;
    logic              MemRespValid;
    logic [63:0]       MemRespData;
    logic              RepEnable;
    logic [63:0]       RepWord;
    logic              FetchStall;

    int nChecks = 0;
    int nErrors = 0;

    instr_refill_ctrl #(
        .B      (B),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .CacheMiss    (CacheMiss),
        .PC           (PC),
        .Flush        (Flush),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemReqReady  (MemReqReady),
        .MemRespValid (MemRespValid),
        .MemRespData  (MemRespData),
        .RepEnable    (RepEnable),
        .RepWord      (RepWord),
        .FetchStall   (FetchStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Idle cycles with stale L2 beats and suppressed misses (miss+flush).
    task automatic idleGap(input int n);
        for (int i = 0; i < n; i++) begin
            CacheMiss    = $urandom_range(0, 1);
            Flush        = CacheMiss;
            PC           = $urandom;
            MemReqReady  = $urandom_range(0, 1);
            MemRespValid = $urandom_range(0, 1);
            MemRespData  = rnd64();
            @(negedge clk);
            chk("idleStall", FetchStall, 0);
            chk("idleNoReq", MemReq, 0);
            chk("idleNoRep", RepEnable, 0);
            chk("idleWordZero", RepWord, 0);
            @(posedge clk); #1;
        end
        CacheMiss = 0; Flush = 0; MemRespValid = 0; MemReqReady = 0;
    endtask

    // One miss transaction.
    //   readyDelay : REQ cycles with ready low before ready rises
    //   validMode  : 0 always valid, 1 toggling 1,0,1,0.., 2 random
    //   flushReqAt : REQ cycle index carrying Flush (-1 none)
    //   flushBeat  : beat index during which Flush is raised (-1 none)
    //   resetAt    : stream index at which reset is pulsed (-1 none)
    //   seqData    : beats are 0x10,0x11,.. instead of random
    task automatic doMiss(input logic [31:0] pc, input int readyDelay, input int validMode,
                          input int flushReqAt, input int flushBeat, input int resetAt,
                          input bit seqData);
        logic [63:0] words[$];
        logic [31:0] expAddr;
        bit          discard;
        bit          v;
        int          beats;
        int          fc;

        expAddr = pc & ~32'h0000_003F;

        // Miss cycle (IDLE).
        CacheMiss    = 1; PC = pc; Flush = 0; MemReqReady = 0;
        MemRespValid = $urandom_range(0, 1); MemRespData = rnd64();
        @(negedge clk);
        chk("missStall", FetchStall, 1);
        chk("missNoReq", MemReq, 0);
        @(posedge clk); #1;
        CacheMiss = 0; PC = $urandom;

        // Request phase.
        for (int d = 0; d <= readyDelay; d++) begin
            MemReqReady  = (d == readyDelay);
            Flush        = (d == flushReqAt);
            MemRespValid = $urandom_range(0, 1); MemRespData = rnd64();
            @(negedge clk);
            chk("reqValid", MemReq, 1);
            chk("reqAddr", MemAddr, expAddr);
            chk("reqStall", FetchStall, 1);
            chk("reqNoRep", RepEnable, 0);
            @(posedge clk); #1;
            if (Flush && !MemReqReady) begin
                Flush = 0; MemReqReady = 0; MemRespValid = 0;
                @(negedge clk);
                chk("flushReqIdle", FetchStall, 0);
                chk("flushReqNoReq", MemReq, 0);
                @(posedge clk); #1;
                return;
            end
        end
        discard = (flushReqAt == readyDelay);
        Flush = 0; MemReqReady = $urandom_range(0, 1);

        // Fill phase: the bench decides when beats arrive.
        beats = 0; fc = 0;
        while (beats < BEATS) begin
            case (validMode)
                0:       v = 1;
                1:       v = (fc % 2 == 0);
                default: v = (fc > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            Flush        = v && (beats == flushBeat);
            MemRespValid = v;
            MemRespData  = seqData ? 64'h10 + 64'(beats) : rnd64();
            @(negedge clk);
            chk("fillNoRep", RepEnable, 0);
            chk("fillWordZero", RepWord, 0);
            chk("fillNoReq", MemReq, 0);
            chk("fillStall", FetchStall, 1);
            if (v) begin
                words.push_back(MemRespData);
                beats++;
                if (Flush) discard = 1;
            end
            @(posedge clk); #1;
            fc++;
        end
        Flush = 0; MemRespValid = 0;

        if (discard) begin
            for (int k = 0; k < BEATS + 2; k++) begin
                MemRespValid = $urandom_range(0, 1); MemRespData = rnd64();
                @(negedge clk);
                chk("discardNoRep", RepEnable, 0);
                chk("discardIdle", FetchStall, 0);
                @(posedge clk); #1;
            end
            MemRespValid = 0;
            return;
        end

        // Stream phase: flush and stray beats must be ignored.
        for (int k = 0; k < BEATS; k++) begin
            Flush        = $urandom_range(0, 1);
            MemRespValid = $urandom_range(0, 1); MemRespData = rnd64();
            @(negedge clk);
            chk("streamEn", RepEnable, 1);
            chk("streamWord", RepWord, words[k]);
            chk("streamStall", FetchStall, 1);
            if (k == resetAt) begin
                #1 reset = 0;
                #1;
                chk("rstRepEn", RepEnable, 0);
                chk("rstRepWord", RepWord, 0);
                chk("rstMemReq", MemReq, 0);
                chk("rstMemAddr", MemAddr, 0);
                Flush = 0;
                #1;
                chk("rstStall", FetchStall, 0);
                @(posedge clk); #2;
                reset = 1;
                for (int j = 0; j < BEATS + 2; j++) begin
                    MemRespValid = 1; MemRespData = rnd64();
                    @(negedge clk);
                    chk("postRstNoRep", RepEnable, 0);
                    chk("postRstIdle", FetchStall, 0);
                    chk("postRstNoReq", MemReq, 0);
                    @(posedge clk); #1;
                end
                MemRespValid = 0;
                return;
            end
            @(posedge clk); #1;
        end

        // Done cycle: a new miss here must not be taken.
        Flush = 0; MemRespValid = 0;
        CacheMiss = 1; PC = $urandom;
        @(negedge clk);
        chk("doneNoRep", RepEnable, 0);
        chk("doneWordZero", RepWord, 0);
        chk("doneStall", FetchStall, 1);
        @(posedge clk); #1;
        CacheMiss = 0;
        @(negedge clk);
        chk("backToIdle", FetchStall, 0);
        chk("idleNoReq", MemReq, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("doneMissIgnored", MemReq, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 0; CacheMiss = 0; PC = '0; Flush = 0;
        MemReqReady = 0; MemRespValid = 0; MemRespData = '0;
        #12;
        chk("rstMemReq0", MemReq, 0);
        chk("rstMemAddr0", MemAddr, 0);
        chk("rstRepEn0", RepEnable, 0);
        chk("rstRepWord0", RepWord, 0);
        chk("rstStall0", FetchStall, 0);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;

        // Basic miss, back-to-back handshakes, known data.
        doMiss(32'h0000_1234, 0, 0, -1, -1, -1, 1);
        idleGap(2);
        // L2 holds off acceptance.
        doMiss(32'hABCD_EF7C, 5, 0, -1, -1, -1, 0);
        idleGap(2);
        // Bursty response.
        doMiss(32'h0000_0040, 0, 1, -1, -1, -1, 1);
        idleGap(2);
        // Redirect before acceptance.
        doMiss(32'h1000_0008, 5, 0, 2, -1, -1, 0);
        idleGap(2);
        // Redirect during fill at beat 3.
        doMiss(32'h2000_00FF, 1, 2, -1, 3, -1, 0);
        idleGap(2);
        // Redirect on the acceptance edge.
        doMiss(32'h3000_0100, 2, 0, 2, -1, -1, 0);
        idleGap(2);
        // Reset in the middle of streaming.
        doMiss(32'h4000_0200, 0, 0, -1, -1, 4, 0);
        idleGap(2);
        doMiss(32'h0000_1234, 0, 0, -1, -1, -1, 1);

        for (int t = 0; t < 30; t++) begin
            int rd, fr, fb;
            rd = $urandom_range(0, 4);
            fr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, rd)) : -1;
            fb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
            idleGap($urandom_range(0, 3));
            doMiss($urandom, rd, $urandom_range(0, 2), fr, fb, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/instr_refill_ctrl.md
INSTR_REFILL_CTRL -- requirements
Module: instr_refill_ctrl

Interface
REQ-001 SHALL have parameter B, default 64, meaning cache block size in bytes (power of two, >=16).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning fetch address width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port CacheMiss  input  1  miss from the active instruction-cache set.
REQ-006 SHALL have port PC  input  ADDR_W  fetch address of the missing instruction.
REQ-007 SHALL have port Flush  input  1  pipeline redirect, cancels a pending refill.
REQ-008 SHALL have port MemReq  output  1  line request valid to L2.
REQ-009 SHALL have port MemAddr  output  ADDR_W  line-aligned request address.
REQ-010 SHALL have port MemReqReady  input  1  L2 accepts request.
REQ-011 SHALL have port MemRespValid  input  1  response beat valid.
REQ-012 SHALL have port MemRespData  input  64  response beat.
REQ-013 SHALL have port RepEnable  output  1  refill stream active toward cache set.
REQ-014 SHALL have port RepWord  output  64  refill beat toward cache set.
REQ-015 SHALL have port FetchStall  output  1  hold fetch stage.

Function
REQ-016 SHALL define BEATS = B/8; beat counter width clog2(BEATS).
REQ-017 SHALL implement states IDLE, REQ, FILL, STREAM, DONE.
REQ-018 IDLE: CacheMiss=1 and Flush=0 SHALL latch line address {PC[ADDR_W-1:clog2(B)], zeros} and go to REQ next edge; otherwise remain IDLE.
REQ-019 REQ: MemReq SHALL be 1 with MemAddr stable until the edge where MemReqReady=1, then go to FILL with counter 0.
REQ-020 REQ with Flush=1 and MemReqReady=0 SHALL return to IDLE with no request issued; Flush=1 with MemReqReady=1 SHALL enter FILL with a discard flag set.
REQ-021 FILL: each edge with MemRespValid=1 SHALL write MemRespData into buffer[counter] and increment counter; beats arrive in ascending address order.
REQ-022 FILL: on the BEATS-th beat SHALL go to STREAM (counter 0), or to IDLE if the discard flag is set; Flush in FILL SHALL set the discard flag and keep draining.
REQ-023 STREAM: RepEnable SHALL be 1 for exactly BEATS consecutive cycles with RepWord = buffer[k] in stream cycle k; no gaps permitted; Flush ignored.
REQ-024 After the last stream beat SHALL spend exactly one cycle in DONE (RepEnable=0) then go to IDLE, ignoring CacheMiss during DONE.
REQ-025 MemRespValid outside FILL SHALL be ignored.
REQ-026 FetchStall SHALL equal (state!=IDLE) OR (CacheMiss AND NOT Flush), combinationally.
REQ-027 Minimum miss-to-IDLE latency with MemReqReady and MemRespValid always 1 SHALL be 1 + 1 + BEATS + BEATS + 1 cycles.
REQ-028 RepWord SHALL be 0 whenever RepEnable=0.

Reset
REQ-029 reset=0 SHALL asynchronously force state IDLE, counter 0, discard flag 0, MemReq 0, MemAddr 0, RepEnable 0, RepWord 0.
REQ-030 Line buffer contents SHALL NOT be reset.
REQ-031 Reset mid-refill SHALL abandon the transfer; stale L2 beats arriving afterward fall under REQ-025.

Structure
REQ-032 State encoding, BEATS derivation and beat-index width SHALL live in a shared package used by cache-side modules.
REQ-033 The line buffer SHALL be one sub-module, refill_line_buffer: BEATS x 64, one write port, one combinational read port.

Verification (B=64, BEATS=8)
REQ-034 Miss PC=0x0000_1234, ready/valid always 1, beats 0x10..0x17 -> MemAddr=0x0000_1200, RepEnable high 8 consecutive cycles emitting 0x10..0x17, IDLE 19 cycles after miss.
REQ-035 MemReqReady held 0 for 5 cycles -> MemReq and MemAddr stable throughout, FILL entered on cycle ready=1.
REQ-036 MemRespValid toggling 1,0,1,0 -> 8 beats captured in order, STREAM still gap-free.
REQ-037 Flush in REQ with ready=0 -> IDLE next edge, MemReq never sampled with ready; Flush in FILL at beat 3 -> remaining beats drained, RepEnable never asserted.
REQ-038 reset=0 asserted mid-STREAM beat 4 -> RepEnable and RepWord 0 immediately, IDLE after release, later MemRespValid ignored.
